// File: rtl/mnist_pkg.sv
// Shared types and sizing for the quantized MNIST inference datapath.
package mnist_pkg;

    localparam int DATA_W      = 16;
    localparam int NUM_CLASSES = 10;

    typedef logic signed [DATA_W-1:0] score_t;

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_OUT   = 1'b1
    } argmax_state_e;

endpackage

// File: rtl/argmax_classifier.sv
// Output-layer argmax: tracks the running max score per frame and reports
// the winning class, a frame-length error flag and a completed-frame count.
module argmax_classifier #(
    parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
    parameter int DATA_W      = mnist_pkg::DATA_W,
    localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_score,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_class,
    output logic signed [DATA_W-1:0] out_score,
    output logic                     out_err,
    output logic [15:0]              frame_cnt
);
    import mnist_pkg::*;

    argmax_state_e             state;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          max_idx;
    logic signed [DATA_W-1:0]  max_score;

    logic                      accept;
    logic                      last_slot;
    logic                      frame_end;
    logic                      take;
    logic [IDX_W-1:0]          next_idx;
    logic signed [DATA_W-1:0]  next_score;

    assign in_ready  = (state == S_ACCUM);
    assign accept    = in_valid && in_ready;
    assign last_slot = (idx == IDX_W'(NUM_CLASSES - 1));
    assign frame_end = accept && (in_last || last_slot);

    // First beat always seeds; later beats need strictly greater so ties keep the lower index.
    assign take       = (idx == '0) || (in_score > max_score);
    assign next_idx   = take ? idx : max_idx;
    assign next_score = take ? in_score : max_score;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_ACCUM;
            idx       <= '0;
            max_idx   <= '0;
            max_score <= '0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_score <= '0;
            out_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            unique case (state)
                S_ACCUM: begin
                    if (accept) begin
                        max_idx   <= next_idx;
                        max_score <= next_score;
                        if (frame_end) begin
                            out_class <= next_idx;
                            out_score <= next_score;
                            out_err   <= in_last ^ last_slot;
                            out_valid <= 1'b1;
                            idx       <= '0;
                            state     <= S_OUT;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= S_ACCUM;
                    end
                end
                default: state <= S_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: vector table plus hand-written
// sequences for backpressure, stalls and reset during a frame.
module tb_argmax_classifier;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_score;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_class;
    logic signed [15:0] out_score;
    logic               out_err;
    logic [15:0]        frame_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    typedef struct {
        logic [159:0] sc;
        int           n;
        int           last_at;
        int           cls;
        int           score;
        bit           err;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    argmax_classifier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_score  (in_score),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score),
        .out_err   (out_err),
        .frame_cnt (frame_cnt)
    );

    function automatic logic [159:0] pk(input int a0, input int a1,
                                        input int a2, input int a3,
                                        input int a4, input int a5,
                                        input int a6, input int a7,
                                        input int a8, input int a9);
        return {16'(a9), 16'(a8), 16'(a7), 16'(a6), 16'(a5),
                16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic check(input string name,
                         input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Called at a negedge in accumulate state; returns at a negedge.
    task automatic drive_frame(input logic [159:0] sc, input int n,
                               input int last_at, input int gap_at);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                in_valid = 1'b0;
                repeat (5) @(negedge clk);
                check("stall_valid", out_valid, 0);
            end
            if (i == n - 1) begin
                check("pre_valid", out_valid, 0);
                check("pre_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            in_score = sc[i*16 +: 16];
            in_last  = (i == last_at);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int cls,
                                input int score, input bit err);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_class"}, out_class, cls);
        check({tag, "_score"}, out_score, score);
        check({tag, "_err"}, out_err, err);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        check({tag, "_hs_valid"}, out_valid, 0);
        check({tag, "_hs_ready"}, in_ready, 1);
        check({tag, "_cnt"}, frame_cnt, exp_cnt);
    endtask

    initial begin
        vecs[0] = '{pk(5, 90, 12, 90, 0, 3, 7, 1, 2, 60), 10, 9, 1, 90, 1'b0};
        vecs[1] = '{pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 10, 9, 0, 0, 1'b0};
        vecs[2] = '{pk(-3, -1, -7, -4, -5, -6, -8, -9, -10, -2), 10, 9, 1, -1, 1'b0};
        vecs[3] = '{pk(1, 2, 3, 9, 4, 0, 0, 0, 0, 0), 5, 4, 3, 9, 1'b1};
        vecs[4] = '{pk(4, 4, 4, 4, 4, 4, 4, 4, 4, 4), 10, -1, 0, 4, 1'b1};
        vecs[5] = '{pk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10), 10, 9, 9, 10, 1'b0};
        vecs[6] = '{pk(-32768, -32768, -32768, -32768, -32768,
                       32767, -32768, -32768, -32768, -32768),
                    10, 9, 5, 32767, 1'b0};
        vecs[7] = '{pk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 7, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_score  = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        exp_cnt   = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_class", out_class, 0);
        check("rst_score", out_score, 0);
        check("rst_err", out_err, 0);
        check("rst_cnt", frame_cnt, 0);

        for (int v = 0; v < 8; v++) begin
            drive_frame(vecs[v].sc, vecs[v].n, vecs[v].last_at, -1);
            check_result($sformatf("v%0d", v), vecs[v].cls,
                         vecs[v].score, vecs[v].err);
            handshake($sformatf("v%0d", v));
        end

        // Backpressure: result must hold and no beat may enter during S_OUT.
        out_ready = 1'b0;
        drive_frame(vecs[0].sc, 10, 9, -1);
        check_result("hold0", 1, 90, 1'b0);
        in_valid = 1'b1;
        in_score = 16'sd1000;
        in_last  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_result($sformatf("hold%0d", c + 1), 1, 90, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_cnt++;
        check("hold_rel_valid", out_valid, 0);
        check("hold_rel_ready", in_ready, 1);
        check("hold_rel_cnt", frame_cnt, exp_cnt);
        drive_frame(vecs[5].sc, 10, 9, -1);
        check_result("after_hold", 9, 10, 1'b0);
        handshake("after_hold");

        // Reset while a result is pending.
        out_ready = 1'b0;
        drive_frame(vecs[2].sc, 10, 9, -1);
        check_result("pend", 1, -1, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt = 0;
        check("rst_out_ready", in_ready, 1);
        check("rst_out_cnt", frame_cnt, 0);
        check("rst_out_class", out_class, 0);
        check("rst_out_score", out_score, 0);

        // Reset after 6 beats, then a stalled full frame with max at index 8.
        drive_frame(pk(100, 200, 500, 300, 1, 2, 0, 0, 0, 0), 6, -1, -1);
        check("part_valid", out_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("part_cnt", frame_cnt, 0);
        drive_frame(pk(3, 1, 4, 1, 5, 9, 2, 6, 50, 7), 10, 9, 4);
        check_result("max8", 8, 50, 1'b0);
        handshake("max8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/argmax_classifier.md
# argmax_classifier

Final stage of the quantized MNIST inference datapath. Consumes the ReLU-saturated signed 16-bit scores of the output-layer neurons, one per beat over a valid/ready stream. Tracks the running maximum and reports the winning class index with its score once per frame. Also flags malformed frames and counts completed classifications.

## Interface
Parameters:
- `NUM_CLASSES`, 10: scores per frame (≥2).
- `DATA_W`, 16: score width, signed.
- `IDX_W`, `$clog2(NUM_CLASSES)`: class index width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  score beat present.
- `in_ready`  out  1  block can accept a beat.
- `in_score`  in  DATA_W  signed neuron result.
- `in_last`  in  1  producer marks final beat of frame.
- `out_valid`  out  1  classification available.
- `out_ready`  in  1  consumer accepts classification.
- `out_class`  out  IDX_W  index of maximum score.
- `out_score`  out  DATA_W  maximum score, signed.
- `out_err`  out  1  frame length mismatch on this result.
- `frame_cnt`  out  16  completed classifications, wraps.

## Operation
- States: `S_ACCUM`, `S_OUT`. Reset state `S_ACCUM`.
- Beat accepted when `in_valid && in_ready`; `in_ready = (state == S_ACCUM)`.
- `S_ACCUM`:
  - Beat index counter `idx` runs 0..NUM_CLASSES-1.
  - Beat at `idx==0` loads `max_score <= in_score`, `max_idx <= 0` unconditionally.
  - Later beats replace only on strictly greater signed compare, so ties keep the lowest index.
  - Frame ends on the first accepted beat with `in_last==1` or `idx==NUM_CLASSES-1`.
  - At frame end: latch `out_class`/`out_score` (including that beat's compare), set `out_err = in_last ^ (idx==NUM_CLASSES-1)`, clear `idx`, go to `S_OUT`.
- `S_OUT`:
  - `out_valid=1`; outputs are held stable until `out_ready`.
  - On `out_valid && out_ready`: `frame_cnt <= frame_cnt+1` (wrap 0xFFFF→0), go to `S_ACCUM`.
  - No beats accepted in `S_OUT`, including in the handshake cycle.
- Arithmetic: signed DATA_W compare only; no widening, no saturation. Negative scores are legal even though ReLU normally prevents them.
- `out_err` frame: the result is still reported using the beats received. Beats with `in_last` after a forced end at NUM_CLASSES start a new frame.

## Timing
- Reset (async assert, sync-safe deassert):
  - `out_valid=0`, `out_class=0`, `out_score=0`, `out_err=0`, `frame_cnt=0`, `in_ready=1` after reset release.
  - Internal `idx=0`, `max_*=0`.
- Latency: `out_valid` rises the cycle after the final beat is accepted.
- Throughput: back-to-back frame takes NUM_CLASSES + 1 cycles with `out_ready` tied high.
- `in_ready` drops the cycle after the final beat and rises the cycle after the output handshake.
- Reset mid-frame or while `S_OUT`: partial frame and pending result are discarded; `frame_cnt` is not incremented.
- `in_valid` low mid-frame: stall; state retained indefinitely.

## Structure
- Shared package `mnist_pkg`: `DATA_W`, `NUM_CLASSES`, `score_t` (`logic signed [DATA_W-1:0]`), and the enum `argmax_state_e {S_ACCUM, S_OUT}`.
- Single module, no sub-module: the compare/register slice is too small to split.

## Test plan
- Scores 5,90,12,90,0,3,7,1,2,60 with `in_last` on beat 9, `out_ready=1` → `out_class=1`, `out_score=90`, `out_err=0`, `out_valid` one cycle after beat 9, `frame_cnt=1`.
- All ten scores 0 → `out_class=0`, `out_score=0`.
- Scores -3,-1,-7,... (beat 1 largest) → `out_class=1`, `out_score=-1` (signed compare).
- `in_last` on beat 4 (scores 1,2,3,9,4) → `out_class=3`, `out_err=1`. Separately, 10 beats with no `in_last` → `out_err=1`.
- Hold `out_ready=0` for 20 cycles → `out_valid` and outputs stable and `in_ready=0` throughout; release → one handshake, `in_ready=1` next cycle.
- Assert `rst` after 6 beats, then a full frame with max at index 8 → `out_class=8`, `frame_cnt=1` (the aborted frame is not counted).
